prog_sequencer: RTL and testbench

Program-flow controller for the 9-bit core. It owns the program counter and runs the Start/Done handshake with the test harness. It applies the jump decisions produced by the instruction decoder and an ALU condition flag, and counts retired instructions. It sits between the decoder (jump enable, jump pointer, done) and the instruction ROM address input.

---
 rtl/prog_sequencer.sv | 169 ++++++++++++++++
 tb/tb_prog_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// prog_sequencer
//
// Program-flow controller for the 9-bit core. Owns the program counter, runs the
// Start/Done handshake with the test harness, applies decoder jump decisions gated by
// the ALU condition flag, and counts retired instructions.
//
// Build option:
//   PROG_SEQ_REL_JUMP_EN  defined   -> jump target = PC + sign-extended Jptr[5:0]
//                         undefined -> jump target = zero-extended Jptr[5:0] (absolute)
//
// Parameters:
//   PC_W      program counter width
//   START_PC  address loaded into the PC when a program is armed
//   CNT_W     retired-instruction counter width
//
// Ports:
//   Clk       in   clock, all state on the rising edge
//   Reset     in   synchronous active-high reset
//   Start     in   harness arm/launch level
//   Jen       in   decoder jump enable
//   Jptr      in   decoder jump pointer, bits [5:0] used
//   Cond      in   ALU condition flag, jump taken only when Jen && Cond
//   DoneIn    in   decoder halt indication
//   Prog_ctr  out  instruction ROM address
//   FetchEn   out  instruction at Prog_ctr executes this cycle (state is RUN)
//   Done      out  program finished, held until the next arm
//   InstrCnt  out  retired-instruction count, saturating
module prog_sequencer #(
    parameter int unsigned PC_W     = 10,
    parameter int unsigned START_PC = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Jen,
    input  logic [7:0]       Jptr,
    input  logic             Cond,
    input  logic             DoneIn,
    output logic [PC_W-1:0]  Prog_ctr,
    output logic             FetchEn,
    output logic             Done,
    output logic [CNT_W-1:0] InstrCnt
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StArmed = 2'd1;
    localparam logic [1:0] StRun   = 2'd2;
    localparam logic [1:0] StHalt  = 2'd3;

    // Jump arithmetic is done at least 6 bits wide so a narrow PC still sees the
    // full pointer before truncation.
    localparam int unsigned EXT_W = (PC_W > 6) ? PC_W : 6;

    logic [1:0]       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             fetch_en_q, fetch_en_d;

    logic [EXT_W-1:0] jptr_ext;
    logic [EXT_W-1:0] jump_sum;
    logic [PC_W-1:0]  jump_target;
    logic [CNT_W-1:0] cnt_inc;
    logic             unused_jptr_hi;

    assign unused_jptr_hi = ^Jptr[7:6];

`ifdef PROG_SEQ_REL_JUMP_EN
    // Relative: signed offset from the current instruction, wrapping modulo 2^PC_W.
    always_comb begin
        jptr_ext    = EXT_W'($signed(Jptr[5:0]));
        jump_sum    = jptr_ext + EXT_W'(pc_q);
        jump_target = jump_sum[PC_W-1:0];
    end
`else
    // Absolute: zero-extended pointer, addresses 0..63.
    always_comb begin
        jptr_ext    = EXT_W'(Jptr[5:0]);
        jump_sum    = jptr_ext;
        jump_target = jump_sum[PC_W-1:0];
    end
`endif

    // Saturating increment: the counter sticks at all-ones.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        done_d  = done_q;

        case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = StArmed;
                    pc_d    = PC_W'(START_PC);
                    cnt_d   = '0;
                end
            end
            StArmed: begin
                if (Start) begin
                    pc_d = PC_W'(START_PC);
                end else begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (Start) begin
                    // Abort: nothing retires this cycle.
                    state_d = StArmed;
                    pc_d    = PC_W'(START_PC);
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (DoneIn) begin
                        // Halt beats a simultaneous jump; the PC holds.
                        state_d = StHalt;
                        done_d  = 1'b1;
                    end else if (Jen && Cond) begin
                        pc_d = jump_target;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            StHalt: begin
                if (Start) begin
                    state_d = StArmed;
                    pc_d    = PC_W'(START_PC);
                    cnt_d   = '0;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                pc_d    = '0;
                cnt_d   = '0;
                done_d  = 1'b0;
            end
        endcase

        // Registered from the next state so FetchEn lines up with the RUN cycle.
        fetch_en_d = (state_d == StRun);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= StIdle;
            pc_q       <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            fetch_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            fetch_en_q <= fetch_en_d;
        end
    end

    assign Prog_ctr = pc_q;
    assign FetchEn  = fetch_en_q;
    assign Done     = done_q;
    assign InstrCnt = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: two instances (default widths, and PC_W=4/CNT_W=3 from 12)
// share stimulus and are compared every cycle against a behavioural model.
module tb_prog_sequencer;

    localparam int AW = 10;
    localparam int AC = 16;
    localparam int AS = 0;
    localparam int BW = 4;
    localparam int BC = 3;
    localparam int BS = 12;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_RUN   = 2;
    localparam int M_HALT  = 3;

    logic          Clk;
    logic          Reset;
    logic          Start;
    logic          Jen;
    logic [7:0]    Jptr;
    logic          Cond;
    logic          DoneIn;

    logic [AW-1:0] a_pc;
    logic          a_fe;
    logic          a_done;
    logic [AC-1:0] a_cnt;
    logic [BW-1:0] b_pc;
    logic          b_fe;
    logic          b_done;
    logic [BC-1:0] b_cnt;

    int ma_st, ma_pc, ma_cnt;
    int mb_st, mb_pc, mb_cnt;
    int checks;
    int errors;

    prog_sequencer #(.PC_W(AW), .START_PC(AS), .CNT_W(AC)) dut_a (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .Jen     (Jen),
        .Jptr    (Jptr),
        .Cond    (Cond),
        .DoneIn  (DoneIn),
        .Prog_ctr(a_pc),
        .FetchEn (a_fe),
        .Done    (a_done),
        .InstrCnt(a_cnt)
    );

    prog_sequencer #(.PC_W(BW), .START_PC(BS), .CNT_W(BC)) dut_b (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .Jen     (Jen),
        .Jptr    (Jptr),
        .Cond    (Cond),
        .DoneIn  (DoneIn),
        .Prog_ctr(b_pc),
        .FetchEn (b_fe),
        .Done    (b_done),
        .InstrCnt(b_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural next-state of one sequencer, from the current bench inputs.
    task automatic model_next(input int w, input int cw, input int spc,
                              input int st, input int pc, input int cnt,
                              output int st_n, output int pc_n, output int cnt_n);
        int m;
        int cmax;
        int off;
        m    = 1 << w;
        cmax = (1 << cw) - 1;
        st_n = st;
        pc_n = pc;
        cnt_n = cnt;
        if (Reset) begin
            st_n = M_IDLE; pc_n = 0; cnt_n = 0;
        end else if (Start && st != M_ARMED) begin
            st_n = M_ARMED; pc_n = spc % m; cnt_n = 0;
        end else if (st == M_ARMED) begin
            if (Start) pc_n = spc % m;
            else st_n = M_RUN;
        end else if (st == M_RUN) begin
            cnt_n = (cnt == cmax) ? cnt : cnt + 1;
            if (DoneIn) begin
                st_n = M_HALT;
            end else if (Jen && Cond) begin
`ifdef PROG_SEQ_REL_JUMP_EN
                off = Jptr[5] ? int'(Jptr[5:0]) - 64 : int'(Jptr[5:0]);
                pc_n = (((pc + off) % m) + m) % m;
`else
                off = int'(Jptr[5:0]);
                pc_n = off % m;
`endif
            end else begin
                pc_n = (pc + 1) % m;
            end
        end
    endtask

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        check("a_pc", int'(a_pc), ma_pc);
        check("a_fetch", int'(a_fe), int'(ma_st == M_RUN));
        check("a_done", int'(a_done), int'(ma_st == M_HALT));
        check("a_cnt", int'(a_cnt), ma_cnt);
        check("b_pc", int'(b_pc), mb_pc);
        check("b_fetch", int'(b_fe), int'(mb_st == M_RUN));
        check("b_done", int'(b_done), int'(mb_st == M_HALT));
        check("b_cnt", int'(b_cnt), mb_cnt);
    endtask

    // One clock: apply inputs, advance the model across the edge, compare after it.
    task automatic step(input logic r, input logic s, input logic j, input logic c,
                        input logic d, input logic [7:0] p);
        int st_n, pc_n, cnt_n;
        Reset = r; Start = s; Jen = j; Cond = c; DoneIn = d; Jptr = p;
        @(posedge Clk);
        model_next(AW, AC, AS, ma_st, ma_pc, ma_cnt, st_n, pc_n, cnt_n);
        ma_st = st_n; ma_pc = pc_n; ma_cnt = cnt_n;
        model_next(BW, BC, BS, mb_st, mb_pc, mb_cnt, st_n, pc_n, cnt_n);
        mb_st = st_n; mb_pc = pc_n; mb_cnt = cnt_n;
        #1;
        check_all();
    endtask

    task automatic run_plain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ma_st = M_IDLE; ma_pc = 0; ma_cnt = 0;
        mb_st = M_IDLE; mb_pc = 0; mb_cnt = 0;
        Reset = 1'b1; Start = 1'b0; Jen = 1'b0; Cond = 1'b0; DoneIn = 1'b0; Jptr = 8'h00;

        // Reset, then launch and three sequential instructions.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("reset_pc", int'(a_pc), 0);
        check("reset_fetch", int'(a_fe), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("armed_fetch", int'(a_fe), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("launch_pc", int'(a_pc), AS);
        check("launch_fetch", int'(a_fe), 1);
        check("launch_b_pc", int'(b_pc), BS);
        run_plain(3);
        check("run3_pc", int'(a_pc), AS + 3);
        check("run3_cnt", int'(a_cnt), 3);

        // Halt at PC 5; jump inputs afterwards are ignored.
        run_plain(2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check("halt_done", int'(a_done), 1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3E);
        check("halt_pc", int'(a_pc), 5);
        check("halt_cnt", int'(a_cnt), 6);

        // Reset from HALT; Start=0 alone does not launch.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("rst_halt_done", int'(a_done), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("idle_no_launch", int'(a_fe), 0);

        // Launch, 10 sequential: narrow instance wraps 15->0, ends at 6, saturates at 7.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        run_plain(10);
        check("wrap_b_pc", int'(b_pc), 6);
        check("sat_b_cnt", int'(b_cnt), 7);

        // Branches at PC 40.
        run_plain(30);
        check("at40_pc", int'(a_pc), 40);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3E);
        check("not_taken_pc", int'(a_pc), 41);
`ifdef PROG_SEQ_REL_JUMP_EN
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3F);
`else
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h28);
`endif
        check("back40_pc", int'(a_pc), 40);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3E);
`ifdef PROG_SEQ_REL_JUMP_EN
        check("taken_pc", int'(a_pc), 38);
`else
        check("taken_pc", int'(a_pc), 62);
`endif

        // DoneIn beats a taken jump.
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h05);
        check("prio_pc_hold", int'(a_pc), ma_pc);
        check("prio_done", int'(a_done), 1);

        // Re-arm from HALT, run, then abort mid-RUN.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("rearm_done", int'(a_done), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        run_plain(4);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("abort_pc", int'(a_pc), AS);
        check("abort_cnt", int'(a_cnt), 0);
        check("abort_fetch", int'(a_fe), 0);

        // Reset mid-RUN.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        run_plain(3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("rst_run_pc", int'(a_pc), 0);
        check("rst_run_cnt", int'(a_cnt), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 19) == 0),
                 8'($urandom_range(0, 255)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
